// File: rtl/pong_score_scanner.sv
// rtl/pong_score_scanner.sv - Pong score keeper, win detector and 4-digit display scanner
//
// Counts left/right points from rising edges on point_left/point_right,
// ends the game at WIN_SCORE, and time-multiplexes both scores onto a
// 4-digit seven-segment decoder through en/num/sel. After a win the
// display blinks with a half-period of BLINK_FRAMES full scan frames.
//
// Ports:
//   clk          system clock
//   rst_n        synchronous active-low reset
//   point_left   left player scored (rising-edge sensitive)
//   point_right  right player scored (rising-edge sensitive)
//   clear        new-game request, level sampled every cycle
//   en           decoder enable, low blanks all anodes
//   num          digit value to the decoder
//   sel          digit slot, 0 = rightmost, 3 = leftmost
//   left_score   left player score
//   right_score  right player score
//   game_over    high while the game is over
//   winner       0 = left, 1 = right; meaningful while game_over is high

module pong_score_scanner #(
    parameter int REFRESH_DIV  = 100000,
    parameter int WIN_SCORE    = 3,
    parameter int BLINK_FRAMES = 125
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       point_left,
    input  logic       point_right,
    input  logic       clear,
    output logic       en,
    output logic [2:0] num,
    output logic [1:0] sel,
    output logic [2:0] left_score,
    output logic [2:0] right_score,
    output logic       game_over,
    output logic       winner
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int FW = $clog2(BLINK_FRAMES + 1);

    typedef enum logic {
        ST_PLAY = 1'b0,
        ST_OVER = 1'b1
    } state_t;

    state_t          state_q;
    state_t          state_d;

    logic            prev_left;
    logic            prev_right;
    logic            edge_left;
    logic            edge_right;

    logic [CW-1:0]   scan_q;
    logic [CW-1:0]   scan_d;
    logic            scan_tc;
    logic [1:0]      sel_d;
    logic            frame_wrap;

    logic [FW-1:0]   frame_q;
    logic [FW-1:0]   frame_d;
    logic            phase_q;
    logic            phase_d;

    logic [2:0]      left_d;
    logic [2:0]      right_d;
    logic [2:0]      left_inc;
    logic [2:0]      right_inc;
    logic            winner_d;
    logic            en_d;
    logic [2:0]      num_d;

    assign edge_left  = point_left  & ~prev_left;
    assign edge_right = point_right & ~prev_right;

    assign left_inc   = left_score  + 3'd1;
    assign right_inc  = right_score + 3'd1;

    // Scan timing: sel advances on the terminal count of the slot counter;
    // a frame ends when slot 3 hands back to slot 0.
    assign scan_tc    = (scan_q == CW'(REFRESH_DIV - 1));
    assign scan_d     = scan_tc ? '0 : scan_q + CW'(1);
    assign sel_d      = scan_tc ? sel + 2'd1 : sel;
    assign frame_wrap = scan_tc && (sel == 2'd3);

    assign game_over  = (state_q == ST_OVER);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_PLAY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        left_d   = left_score;
        right_d  = right_score;
        winner_d = winner;
        frame_d  = frame_q;
        phase_d  = phase_q;

        if (clear) begin
            // clear wins over any point edge sampled in the same cycle
            state_d  = ST_PLAY;
            left_d   = 3'd0;
            right_d  = 3'd0;
            winner_d = 1'b0;
            frame_d  = '0;
            phase_d  = 1'b1;
        end else begin
            case (state_q)
                ST_PLAY: begin
                    // simultaneous edges cancel: nobody scores
                    if (edge_left && !edge_right) begin
                        left_d = left_inc;
                        if (left_inc == 3'(WIN_SCORE)) begin
                            state_d  = ST_OVER;
                            winner_d = 1'b0;
                            frame_d  = '0;
                            phase_d  = 1'b1;
                        end
                    end else if (edge_right && !edge_left) begin
                        right_d = right_inc;
                        if (right_inc == 3'(WIN_SCORE)) begin
                            state_d  = ST_OVER;
                            winner_d = 1'b1;
                            frame_d  = '0;
                            phase_d  = 1'b1;
                        end
                    end
                end
                ST_OVER: begin
                    if (frame_wrap) begin
                        if (frame_q == FW'(BLINK_FRAMES - 1)) begin
                            frame_d = '0;
                            phase_d = ~phase_q;
                        end else begin
                            frame_d = frame_q + FW'(1);
                        end
                    end
                end
                default: begin
                    state_d = ST_PLAY;
                end
            endcase
        end

        en_d = (state_d == ST_OVER) ? phase_d : 1'b1;

        // num follows the sel value being registered this edge, but uses
        // the score as it stood before this edge.
        case (sel_d)
            2'd0:    num_d = right_score;
            2'd3:    num_d = left_score;
            default: num_d = 3'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_left   <= 1'b0;
            prev_right  <= 1'b0;
            scan_q      <= '0;
            sel         <= 2'd0;
            frame_q     <= '0;
            phase_q     <= 1'b1;
            left_score  <= 3'd0;
            right_score <= 3'd0;
            winner      <= 1'b0;
            en          <= 1'b1;
            num         <= 3'd0;
        end else begin
            prev_left   <= point_left;
            prev_right  <= point_right;
            scan_q      <= scan_d;
            sel         <= sel_d;
            frame_q     <= frame_d;
            phase_q     <= phase_d;
            left_score  <= left_d;
            right_score <= right_d;
            winner      <= winner_d;
            en          <= en_d;
            num         <= num_d;
        end
    end

endmodule

// File: tb/tb_pong_score_scanner.sv
// tb/tb_pong_score_scanner.sv - self-checking bench for pong_score_scanner

module tb_pong_score_scanner;

    localparam int RD = 4;
    localparam int WS = 3;
    localparam int BF = 2;

    logic       clk;
    logic       rst_n;
    logic       point_left;
    logic       point_right;
    logic       clear;
    logic       en;
    logic [2:0] num;
    logic [1:0] sel;
    logic [2:0] left_score;
    logic [2:0] right_score;
    logic       game_over;
    logic       winner;

    pong_score_scanner #(
        .REFRESH_DIV (RD),
        .WIN_SCORE   (WS),
        .BLINK_FRAMES(BF)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .point_left (point_left),
        .point_right(point_right),
        .clear      (clear),
        .en         (en),
        .num        (num),
        .sel        (sel),
        .left_score (left_score),
        .right_score(right_score),
        .game_over  (game_over),
        .winner     (winner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model state
    int m_cyc, m_ls, m_rs, m_over, m_win, m_wraps, m_sel, m_num, m_en;
    int m_prevl, m_prevr;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s got=%0d exp=%0d at t=%0t", tag, got, exp, $time);
    endtask

    // Model one clock edge from the spec rules: sel is derived from the
    // elapsed cycle count, blink phase from the number of frames seen in OVER.
    task automatic model_edge(input int pl, input int pr, input int clr, input int rn);
        int old_ls, old_rs, el, er;
        if (rn == 0) begin
            m_cyc = 0; m_ls = 0; m_rs = 0; m_over = 0; m_win = 0;
            m_wraps = 0; m_prevl = 0; m_prevr = 0;
            m_sel = 0; m_num = 0; m_en = 1;
            return;
        end
        old_ls = m_ls;
        old_rs = m_rs;
        m_cyc++;
        m_sel = (m_cyc / RD) % 4;
        el = (pl == 1 && m_prevl == 0) ? 1 : 0;
        er = (pr == 1 && m_prevr == 0) ? 1 : 0;
        m_prevl = pl;
        m_prevr = pr;
        if (clr != 0) begin
            m_ls = 0; m_rs = 0; m_over = 0; m_win = 0;
        end else if (m_over != 0) begin
            if (m_cyc % (4 * RD) == 0) m_wraps++;
        end else if (el + er == 1) begin
            if (el != 0) m_ls++;
            else m_rs++;
            if (m_ls == WS || m_rs == WS) begin
                m_over = 1;
                m_win = er;
                m_wraps = 0;
            end
        end
        m_en = (m_over != 0) ? (((m_wraps / BF) % 2 == 0) ? 1 : 0) : 1;
        m_num = (m_sel == 0) ? old_rs : ((m_sel == 3) ? old_ls : 0);
    endtask

    task automatic step(input logic pl, input logic pr, input logic clr, input logic rn);
        point_left  = pl;
        point_right = pr;
        clear       = clr;
        rst_n       = rn;
        @(posedge clk);
        model_edge(int'(pl), int'(pr), int'(clr), int'(rn));
        #1;
        check("sel",         int'(sel),         m_sel);
        check("num",         int'(num),         m_num);
        check("en",          int'(en),          m_en);
        check("left_score",  int'(left_score),  m_ls);
        check("right_score", int'(right_score), m_rs);
        check("game_over",   int'(game_over),   m_over);
        check("winner",      int'(winner),      m_win);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic pulse(input logic pl, input logic pr);
        step(pl, pr, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        point_left  = 1'b0;
        point_right = 1'b0;
        clear       = 1'b0;
        rst_n       = 1'b0;

        // reset, then one full scan frame plus a bit
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
        idle(18);

        // scoring: single left pulse, right held high for 10 cycles
        pulse(1'b1, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 1'b1);
        idle(20);

        // win for right, then a left edge that must be ignored, then blink
        step(1'b0, 1'b0, 1'b1, 1'b1);
        pulse(1'b0, 1'b1);
        pulse(1'b0, 1'b1);
        pulse(1'b0, 1'b1);
        pulse(1'b1, 1'b0);
        idle(110);

        // simultaneous edges cancel
        step(1'b0, 1'b0, 1'b1, 1'b1);
        pulse(1'b1, 1'b1);
        idle(3);

        // left wins, then clear together with a left edge
        pulse(1'b1, 1'b0);
        pulse(1'b1, 1'b0);
        pulse(1'b1, 1'b0);
        idle(5);
        step(1'b1, 1'b0, 1'b1, 1'b1);
        idle(6);

        // reset mid-operation with 2/1 showing in slot 3
        step(1'b0, 1'b0, 1'b1, 1'b1);
        pulse(1'b1, 1'b0);
        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b1);
        for (int i = 0; i < 20 && m_sel != 3; i++) idle(1);
        idle(1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        idle(10);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 149) == 0),
                 ($urandom_range(0, 399) != 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pong_score_scanner.md
# pong_score_scanner

Score keeper and digit scanner for the Pong scoreboard. It counts points for the left and right players and detects a win. It time-multiplexes both scores onto the 4-digit seven-segment display by driving the `en`/`num`/`sel` inputs of the seven-segment decoder. Once a game ends, it blinks the display. It sits between the game-logic point pulses and the seven-segment decoder.

## Interface
Parameters:
- `REFRESH_DIV`, default 100000. Clock cycles per digit slot (1 ms at 100 MHz). Must be ≥ 2.
- `WIN_SCORE`, default 3. Score that ends the game. Range 1..3, because the decoder renders only 0..3.
- `BLINK_FRAMES`, default 125. Full 4-digit scan frames per blink half-period. Must be ≥ 1.

Ports:
- Clocking and reset: one clock; reset is synchronous and active-low.
  - `clk`, in, 1: system clock.
  - `rst_n`, in, 1: synchronous active-low reset.
- Inputs:
  - `point_left`, in, 1: left player scored. Rising-edge sensitive.
  - `point_right`, in, 1: right player scored. Rising-edge sensitive.
  - `clear`, in, 1: synchronous new-game request. Level sampled each cycle.
- Outputs:
  - `en`, out, 1: decoder enable. Low blanks all anodes.
  - `num`, out, 3: digit value to the decoder.
  - `sel`, out, 2: digit slot. 0 = rightmost, 3 = leftmost.
  - `left_score`, out, 3: left player score.
  - `right_score`, out, 3: right player score.
  - `game_over`, out, 1: high while in state OVER.
  - `winner`, out, 1: 0 = left, 1 = right. Valid only while `game_over` is high.

## Operation
Reset, while `rst_n` = 0 at a clock edge:
- Scores = 0; state = PLAY; `game_over` = 0; `winner` = 0.
- `sel` = 0; `num` = 0; `en` = 1.
- Scan counter = 0; frame counter = 0; blink phase = on.
- Edge-detect registers = 0. An input held high through reset therefore counts as one rising edge on the first cycle after reset.

Edge detection:
- An edge on `point_x` is defined as `point_x` = 1 this cycle and 0 in the previous sampled cycle.

Scoring in state PLAY:
- Edge on exactly one input: that score increments by 1.
- Edges on both inputs in the same cycle: ignored. Neither score changes.
- If the incremented score equals `WIN_SCORE`: go to OVER, set `game_over` = 1, and set `winner` to the scorer.
- Scores never exceed `WIN_SCORE`.

State OVER:
- All point edges are ignored. Scores hold.

`clear`:
- In either state, `clear` = 1 zeros both scores, sets state = PLAY, `game_over` = 0 and `winner` = 0.
- `clear` beats a point edge in the same cycle. That edge is discarded.
- The scan counter and `sel` are not reset by `clear`.

Scanning:
- The scan counter counts 0..`REFRESH_DIV`-1 and wraps.
- On terminal count, `sel` advances 0→1→2→3→0.
- `num` is the right score when `sel` = 0, the left score when `sel` = 3, and 0 when `sel` = 1 or 2. The decoder blanks those two slots itself.
- `num` is registered from the next-cycle `sel` and the current score register, so `sel` and `num` always change on the same edge.

Blink:
- In PLAY, `en` = 1.
- On entry to OVER: frame counter = 0, blink phase = on.
- Each `sel` wrap 3→0 in OVER increments the frame counter.
- When the frame counter reaches `BLINK_FRAMES`, the blink phase toggles and the frame counter returns to 0.
- `en` = blink phase while in OVER.
- On leaving OVER (`clear`), `en` = 1 on the next edge.

## Timing
- `en`, `num`, `sel`, `left_score`, `right_score`, `game_over` and `winner` are all registered.
- Point pulses:
  - A point input high at edge k (and low at edge k-1) updates the score at edge k.
  - `game_over` and `winner` update at edge k.
  - `num` shows the new score at edge k+1 if the matching slot is selected.
- Scan period:
  - `sel` holds each value for exactly `REFRESH_DIV` cycles.
  - Full frame = 4·`REFRESH_DIV` cycles.
- Blink half-period = `BLINK_FRAMES`·4·`REFRESH_DIV` cycles. The first half-period starts at OVER entry, measured to frame boundaries.
- `clear` takes effect at the edge where it is sampled high.
- Reset mid-scan or mid-blink restores all reset values at that edge, with no residual state.

## Test plan
Simulation settings: `REFRESH_DIV` = 4, `WIN_SCORE` = 3, `BLINK_FRAMES` = 2.

- **Reset:** hold `rst_n` = 0 for 3 cycles, then release. Expect `sel` = 0, `num` = 0, `en` = 1, scores 0, `game_over` = 0. Expect `sel` = 1 after 4 cycles, then 2, 3, 0 at 4-cycle spacing.
- **Scoring:** one 1-cycle `point_left` pulse, then `point_right` held high for 10 cycles. Expect `left_score` = 1 and `right_score` = 1, the held pulse counting once. `num` = 1 in slots 3 and 0; `num` = 0 in slots 1 and 2.
- **Win:** three `point_right` edges. Expect `right_score` = 3, `game_over` = 1 and `winner` = 1 on the third edge. A following `point_left` edge leaves `left_score` unchanged.
- **Blink:** after the win, expect `en` = 1 for 2 frames (32 cycles), 0 for 32 cycles, then 1 again.
- **Simultaneous events:**
  - `point_left` and `point_right` rising on the same cycle: no score change.
  - `clear` with a `point_left` edge on the same cycle in OVER: scores 0, `game_over` = 0, `en` = 1 next edge, and `left_score` stays 0.
- **Reset mid-operation:** with scores 2/1 in slot 3, assert `rst_n` = 0 for one edge. Expect all reset values at that edge, and scanning restarts from `sel` = 0 with a full 4-cycle slot.
